// File: rtl/ddr2_sys_onchip_mem_dp_arb.sv
// Dual-port Avalon-MM on-chip SRAM: s1/s2 round-robin arbitrated onto one single-port array.
// Latency: read data + readdatavalid RD_LAT (1 or 2) cycles after the grant edge; writes commit at grant.
// Backpressure: waitrequest = request & ~grant (combinational); clken=0 stalls everything. Optional ONCHIP_MEM_PARITY_EN.
module ddr2_sys_onchip_mem_dp_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 163840,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic                s2_waitrequest,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    input  logic                parity_inject,
    output logic                parity_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic                req1, req2, gnt1, gnt2;
    logic                last_s2;          // 1: s2 was granted most recently
    logic                acc_vld, acc_wr, acc_tag, in_range, wr_en, rd_en;
    logic [ADDR_W-1:0]   acc_addr;
    logic [NB-1:0]       acc_be;
    logic [DATA_W-1:0]   acc_wd;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_q;
    logic                v1, t1, z1;       // stage 1: valid, port tag, out-of-range
    logic [DATA_W-1:0]   d1;
    logic                mis1;
    logic                out_v, out_t, out_m, emit;
    logic [DATA_W-1:0]   out_d;

    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    // On conflict the port that did not win last time gets the slot
    assign gnt1 = clken & req1 & (~req2 | last_s2);
    assign gnt2 = clken & req2 & (~req1 | ~last_s2);

    assign s1_waitrequest = req1 & ~gnt1;
    assign s2_waitrequest = req2 & ~gnt2;

    // Steer the granted port onto the single array port; write wins over read
    always_comb begin
        acc_vld  = gnt1 | gnt2;
        acc_tag  = gnt2;
        acc_addr = gnt2 ? s2_address    : s1_address;
        acc_wr   = gnt2 ? s2_write      : s1_write;
        acc_be   = gnt2 ? s2_byteenable : s1_byteenable;
        acc_wd   = gnt2 ? s2_writedata  : s1_writedata;
        in_range = {1'b0, acc_addr} < DEPTH_W;
        wr_en    = acc_vld & acc_wr & in_range;
        rd_en    = acc_vld & ~acc_wr;
        idx      = acc_addr[IDX_W-1:0];
    end

    // Array port: byte-masked write, synchronous read; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (clken) begin
            if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (acc_be[b]) mem[idx][b*8 +: 8] <= acc_wd[b*8 +: 8];
                end
            end
            if (rd_en && in_range) rd_q <= mem[idx];
        end
    end

    // Arbitration history and first read pipeline stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_s2 <= 1'b1;
            v1      <= 1'b0;
            t1      <= 1'b0;
            z1      <= 1'b0;
        end else if (clken) begin
            if (acc_vld) last_s2 <= gnt2;
            v1 <= rd_en;
            t1 <= acc_tag;
            z1 <= ~in_range;
        end
    end

    assign d1 = z1 ? '0 : rd_q;

`ifdef ONCHIP_MEM_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];
    logic [NB-1:0] rp_q;
    logic [NB-1:0] calc;
    logic          err_q;

    // Parity side array tracks the data array one bit per byte
    always_ff @(posedge clk) begin
        if (clken) begin
            if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (acc_be[b]) pmem[idx][b] <= (^acc_wd[b*8 +: 8]) ^ parity_inject;
                end
            end
            if (rd_en && in_range) rp_q <= pmem[idx];
        end
    end

    // Recompute even parity of the returned word
    always_comb begin
        calc = '0;
        for (int b = 0; b < NB; b++) calc[b] = ^rd_q[b*8 +: 8];
    end

    assign mis1 = ~z1 & (|(calc ^ rp_q));

    // Sticky error, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          err_q <= 1'b0;
        else if (emit & out_m) err_q <= 1'b1;
    end

    assign parity_err = err_q | (emit & out_m);
`else
    logic unused_parity_inject;
    assign unused_parity_inject = parity_inject;
    assign mis1       = 1'b0;
    assign parity_err = 1'b0;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2, t2, m2;
            logic [DATA_W-1:0] d2;

            // Output register stage, held together with stage 1 while clken is low
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    t2 <= 1'b0;
                    m2 <= 1'b0;
                    d2 <= '0;
                end else if (clken) begin
                    v2 <= v1;
                    t2 <= t1;
                    m2 <= mis1;
                    d2 <= d1;
                end
            end

            assign out_v = v2;
            assign out_t = t2;
            assign out_m = m2;
            assign out_d = d2;
        end else begin : g_lat1
            assign out_v = v1;
            assign out_t = t1;
            assign out_m = mis1;
            assign out_d = d1;
        end
    endgenerate

    // A held result is shown only in a cycle the pipeline can advance, so it pulses once
    assign emit             = out_v & clken;
    assign s1_readdatavalid = emit & ~out_t;
    assign s2_readdatavalid = emit & out_t;
    assign s1_readdata      = (out_v & ~out_t) ? out_d : '0;
    assign s2_readdata      = (out_v & out_t)  ? out_d : '0;

endmodule

// File: tb/tb_ddr2_sys_onchip_mem_dp_arb.sv
module tb_ddr2_sys_onchip_mem_dp_arb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int RD_LAT = 1;
`ifdef ONCHIP_MEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk, reset_n, clken;
    logic [ADDR_W-1:0] s1_address, s2_address;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic        s1_waitrequest, s1_readdatavalid, s2_waitrequest, s2_readdatavalid;
    logic        parity_inject, parity_err;

    ddr2_sys_onchip_mem_dp_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .parity_inject(parity_inject), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the hand-derived waitrequest it must produce
    typedef struct {
        logic c1, r1, w1; logic [9:0] a1; logic [3:0] be1; logic [31:0] d1;
        logic c2, r2, w2; logic [9:0] a2; logic [3:0] be2; logic [31:0] d2;
        logic ce, ew1, ew2;
    } vec_t;

    typedef struct { logic port; logic [31:0] data; int due; logic bad; } exp_t;

    exp_t        sbq[$];
    logic [31:0] memm [int];
    logic        badm [int];
    vec_t        tbl[$];
    int          checks = 0, failures = 0, cyc = 0;
    logic        pinj = 1'b0, exp_perr = 1'b0;

    function automatic vec_t mk(input logic c1, r1, w1, input logic [9:0] a1, input logic [3:0] be1,
                                input logic [31:0] d1, input logic c2, r2, w2, input logic [9:0] a2,
                                input logic [3:0] be2, input logic [31:0] d2, input logic ce, ew1, ew2);
        vec_t v;
        v = '{c1, r1, w1, a1, be1, d1, c2, r2, w2, a2, be2, d2, ce, ew1, ew2};
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0,0,0,0,0,0, 0,0,0,0,0,0, 1, 0,0);
    endfunction
    function automatic vec_t rd1(input logic [9:0] a);
        return mk(1,1,0,a,0,0, 0,0,0,0,0,0, 1, 0,0);
    endfunction
    function automatic vec_t wr1(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        return mk(1,0,1,a,be,d, 0,0,0,0,0,0, 1, 0,0);
    endfunction
    function automatic vec_t rd2(input logic [9:0] a);
        return mk(0,0,0,0,0,0, 1,1,0,a,0,0, 1, 0,0);
    endfunction
    function automatic vec_t wr2(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        return mk(0,0,0,0,0,0, 1,0,1,a,be,d, 1, 0,0);
    endfunction
    function automatic vec_t both_rd(input logic ew1, ew2);
        return mk(1,1,0,10'd10,0,0, 1,1,0,10'd11,0,0, 1, ew1,ew2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, req, cyc);
        end
    endtask

    // Reference memory: apply a granted access, queueing the read result it owes
    task automatic access(input logic port, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        int ai;
        exp_t e;
        logic [31:0] w;
        ai = int'(a);
        if (wr) begin
            if (ai < DEPTH) begin
                w = memm.exists(ai) ? memm[ai] : 32'h0;
                for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
                memm[ai] = w;
                if (pinj && PAR && be != 4'h0) badm[ai] = 1'b1;
                else if (be == 4'hF)           badm[ai] = 1'b0;
            end
        end else begin
            e.port = port;
            e.due  = cyc + RD_LAT;
            e.data = (ai < DEPTH && memm.exists(ai)) ? memm[ai] : 32'h0;
            e.bad  = (ai < DEPTH && badm.exists(ai)) ? badm[ai] : 1'b0;
            sbq.push_back(e);
        end
    endtask

    task automatic drive(input vec_t v);
        s1_chipselect = v.c1; s1_read = v.r1; s1_write = v.w1; s1_address = v.a1;
        s1_byteenable = v.be1; s1_writedata = v.d1;
        s2_chipselect = v.c2; s2_read = v.r2; s2_write = v.w2; s2_address = v.a2;
        s2_byteenable = v.be2; s2_writedata = v.d2;
        clken = v.ce; parity_inject = pinj;
    endtask

    // Drive on the falling edge, check mid-cycle, then advance the model for this cycle's grants
    task automatic step(input vec_t v);
        logic e1, e2;
        logic [31:0] ed;
        exp_t e;
        @(negedge clk);
        drive(v);
        #1;
        chk("wait1", s1_waitrequest, v.ew1);
        chk("wait2", s2_waitrequest, v.ew2);
        e1 = 0; e2 = 0; ed = 0;
        if (v.ce && sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (e.port) e2 = 1; else e1 = 1;
            ed = e.data;
            if (e.bad) exp_perr = 1'b1;
        end
        chk("rdv1", s1_readdatavalid, e1);
        chk("rdv2", s2_readdatavalid, e2);
        if (e1) chk("rdata1", s1_readdata, ed);
        if (e2) chk("rdata2", s2_readdata, ed);
        chk("parity_err", parity_err, exp_perr);
        if (!v.ce) foreach (sbq[i]) sbq[i].due++;
        if (v.ce && v.c1 && (v.r1 | v.w1) && !v.ew1) access(1'b0, v.w1, v.a1, v.be1, v.d1);
        if (v.ce && v.c2 && (v.r2 | v.w2) && !v.ew2) access(1'b1, v.w2, v.a2, v.be2, v.d2);
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rdv1"}, s1_readdatavalid, 0);
        chk({tag, "_rdv2"}, s2_readdatavalid, 0);
        chk({tag, "_rdata1"}, s1_readdata, 0);
        chk({tag, "_rdata2"}, s2_readdata, 0);
        chk({tag, "_perr"}, parity_err, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(idle());
        // Basic byte-masked write/read, conflict, read-after-write, write priority, range, clken
        tbl.push_back(wr1(10'd5, 4'hF, 32'hDEADBEEF));
        tbl.push_back(wr1(10'd5, 4'h1, 32'h000000AA));
        tbl.push_back(rd1(10'd5));
        tbl.push_back(idle());
        tbl.push_back(wr1(10'd10, 4'hF, 32'h11111111));
        tbl.push_back(wr2(10'd11, 4'hF, 32'h22222222));
        for (int i = 0; i < 6; i++) tbl.push_back(both_rd(i % 2 == 1, i % 2 == 0));
        tbl.push_back(idle());
        tbl.push_back(wr1(10'd100, 4'hF, 32'h12345678));
        tbl.push_back(rd2(10'd100));
        tbl.push_back(wr2(10'd100, 4'hA, 32'hAABBCCDD));
        tbl.push_back(rd1(10'd100));
        tbl.push_back(mk(1,1,1,10'd5,4'h1,32'h00000055, 0,0,0,0,0,0, 1, 0,0));
        tbl.push_back(rd1(10'd5));
        tbl.push_back(rd1(10'(DEPTH)));
        tbl.push_back(wr1(10'(DEPTH), 4'hF, 32'hCAFEF00D));
        tbl.push_back(rd1(10'(DEPTH)));
        tbl.push_back(mk(1,1,0,10'd5,0,0, 0,0,0,0,0,0, 1, 0,0));
        tbl.push_back(idle());
        tbl.push_back(rd2(10'd10));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,1,0,10'd5,0,0, 0,0,0,0,0,0, 0, 1,0));
        tbl.push_back(idle());
        tbl.push_back(mk(0,1,1,10'd5,4'hF,32'hFFFFFFFF, 0,0,0,0,0,0, 1, 0,0));
        tbl.push_back(rd1(10'd5));
        tbl.push_back(idle());

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_wait1", s1_waitrequest, 0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset while an s1 read is in flight: nothing may emit, arbitration history restarts
        step(rd1(10'd5));
        @(negedge clk);
        reset_n = 1'b0;
        drive(idle());
        #1;
        chk_quiet("midrst");
        @(negedge clk);
        #1;
        chk_quiet("midrst2");
        sbq.delete();
        exp_perr = 1'b0;
        reset_n = 1'b1;
        step(both_rd(1'b0, 1'b1));
        step(both_rd(1'b1, 1'b0));
        step(idle());
        step(idle());

        // Injected parity must flag (when built with parity) and stay sticky across clean reads
        pinj = 1'b1;
        step(wr1(10'd7, 4'hF, 32'h0F0F0F0F));
        pinj = 1'b0;
        step(rd1(10'd7));
        step(idle());
        step(wr1(10'd8, 4'hF, 32'h01020304));
        step(rd1(10'd8));
        step(idle());
        step(idle());

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr2_sys_onchip_mem_dp_arb.md
# ddr2_sys_onchip_mem_dp_arb

Parametrised on-chip SRAM with two Avalon-MM slave ports (s1, s2) sharing one inferred single-port array. Requests are arbitrated round-robin, and reads are pipelined with `readdatavalid` and a configurable read latency. The block sits on the ddr2_sys interconnect as scratch/frame-line storage. It replaces the fixed 32-bit, unarbitrated, combinational-read memory.

## Interface
Parameters:
- `DATA_W`, 32: data width; must be a multiple of 8.
- `ADDR_W`, 18: word-address width.
- `DEPTH`, 163840: number of words; must be ≤ 2^ADDR_W.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 or 2 (2 adds an output register).

Ports (clock and reset first):
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  global clock enable; 0 freezes the block.
- `sN_address`  in  ADDR_W  word address (N = 1, 2).
- `sN_byteenable`  in  DATA_W/8  byte write mask.
- `sN_chipselect`  in  1  port select.
- `sN_read`  in  1  read request.
- `sN_write`  in  1  write request.
- `sN_writedata`  in  DATA_W  write data.
- `sN_waitrequest`  out  1  request not accepted this cycle.
- `sN_readdata`  out  DATA_W  read data.
- `sN_readdatavalid`  out  1  `sN_readdata` is valid.
- `parity_inject`  in  1  store inverted parity on writes (macro only; otherwise ignored).
- `parity_err`  out  1  sticky parity error flag (macro only; otherwise tied 0).

## Operation
- Request condition: `reqN = sN_chipselect & (sN_read | sN_write)`.
- Write has priority if read and write are both asserted.
- Arbitration, evaluated each cycle with `clken=1`:
  - One requester: that port is granted.
  - Both requesting: the port not granted last time is granted.
  - `last_grant` resets to s2, so s1 wins the first conflict.
- `sN_waitrequest = reqN & ~grantN`, combinational.
  - With `clken=0`, every requesting port sees `waitrequest=1`.
- Write: committed at the grant edge. Only bytes with `byteenable=1` are updated.
- Read: address is registered at the grant edge, and a port tag travels with it through the pipeline.
  - Data returns only on the issuing port.
  - The other port's `readdatavalid` stays 0.
- Out-of-range address (≥ DEPTH):
  - Writes are dropped.
  - Reads return all-zero data with normal valid timing.
- `clken=0` holds the pipeline stages and forces `readdatavalid=0`. Held results emit when `clken` returns to 1.
- Reset values:
  - `readdatavalid`, `readdata`, and `parity_err` are 0.
  - `last_grant` is s2.
  - Pipeline valids are cleared. In-flight reads are discarded and never emit `readdatavalid`.
  - Array contents are not reset.

## Timing
- Grant at edge E. Read data and `readdatavalid` are high in the cycle after edge E+RD_LAT−1, i.e. 1 or 2 cycles after acceptance.
- Throughput: one access per cycle in total, across both ports.
- Read-after-write to the same word on the next cycle, from either port, returns the new data (no stale read).
- `readdatavalid` is a one-cycle pulse per accepted read. Back-to-back reads give consecutive pulses.

## Configuration
- `ONCHIP_MEM_PARITY_EN` defined:
  - The array stores one even-parity bit per byte, written as the inverse when `parity_inject=1`.
  - Every valid read checks all bytes.
  - Any mismatch sets `parity_err` in the same cycle as `readdatavalid`. It stays set until `reset_n` is asserted.
- Not defined: no parity storage, `parity_inject` is ignored, and `parity_err` is constant 0.

## Test plan
- **Single write/read, s1 only:** write 0xDEADBEEF with byteenable 0xF to address 5, then write 0x000000AA with byteenable 0x1, then read address 5. Expect readdata 0xDEADBEAA, with `s1_readdatavalid` exactly RD_LAT cycles after the read grant.
- **Conflict:** s1 and s2 both read every cycle for 6 cycles. Expect grants s1, s2, s1, s2, … and each `waitrequest` high on alternate cycles. Data returns on the correct port only.
- **Next-cycle read-after-write:** s1 writes 0x12345678 to address 100; s2 reads address 100 on the following cycle. Expect `s2_readdata = 0x12345678`.
- **Out of range and clken:** read address DEPTH → readdata 0 with valid. Drop `clken` for 3 cycles with a read in flight → no valid while `clken=0`, then the held data emits once.
- **Reset mid-read:** pulse `reset_n` low while a read is in flight. Expect no `readdatavalid`, all outputs 0, and the next conflict granted to s1.
- **Parity (macro on):** write address 7 with `parity_inject=1`, then read it → `parity_err` rises with `readdatavalid` and stays high. A normal write/read of another address leaves it set until reset.
